// File: rtl/pb_audio_port.sv
// PicoBlaze I/O peripheral: record FIFO read through an input port, a threshold
// interrupt and a single-entry playback register. Define PB_AUDIO_IRQ_EN for the interrupt.
`timescale 1ns/1ps
module pb_audio_port #(
   parameter logic [7:0]  BASE_ADDR    = 8'h00,
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter logic [7:0]  RESET_THRESH = 8'd8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic       read_strobe,
   input  logic       write_strobe,
   input  logic [7:0] out_port,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   input  logic       rec_valid,
   input  logic [7:0] rec_data,
   output logic       play_valid,
   output logic [7:0] play_data,
   input  logic       play_ready
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [8:0]            addr_diff;
   logic [7:0]            offset;
   logic                  in_window;
   logic                  wr_ctrl, wr_play, wr_thresh, pop_req;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [7:0]            count8;
   logic                  full, empty, do_push, do_pop, flush, clr_flags;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  overrun_q, overrun_d;
   logic                  play_valid_q, play_valid_d;
   logic [7:0]            play_data_q, play_data_d;
   logic                  irq_en_q, irq_q;
   logic [7:0]            thresh_q;
   logic [7:0]            rdata, status;

   // 9-bit difference so ports below BASE_ADDR never alias into the window
   assign addr_diff = {1'b0, port_id} - {1'b0, BASE_ADDR};
   assign offset    = addr_diff[7:0];
   assign in_window = addr_diff < 9'd6;

   assign wr_ctrl   = write_strobe && in_window && (offset == 8'd4);
   assign wr_play   = write_strobe && in_window && (offset == 8'd3);
   assign wr_thresh = write_strobe && in_window && (offset == 8'd5);
   assign pop_req   = read_strobe && in_window && (offset == 8'd0);

   assign full      = count_q == FULL_COUNT;
   assign empty     = count_q == '0;
   assign do_push   = rec_valid && !full;
   assign do_pop    = pop_req && !empty;
   assign flush     = wr_ctrl && out_port[2];
   assign clr_flags = wr_ctrl && out_port[1];
   assign count8    = 8'(count_q);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (!do_push && do_pop) count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      overflow_d   = clr_flags ? 1'b0 : (overflow_q || (rec_valid && full));
      underflow_d  = clr_flags ? 1'b0 : (underflow_q || (pop_req && empty));
      overrun_d    = clr_flags ? 1'b0 : (overrun_q || (wr_play && play_valid_q && !play_ready));
      play_valid_d = play_valid_q;
      play_data_d  = play_data_q;
      if (wr_play) begin
         play_valid_d = 1'b1;
         play_data_d  = out_port;
      end else if (play_valid_q && play_ready) begin
         play_valid_d = 1'b0;
      end
   end

`ifdef PB_AUDIO_IRQ_EN
   logic       irq_en_d, irq_d, armed_q, armed_d, irq_cond;
   logic [7:0] thresh_d;

   always_comb begin
      irq_cond = irq_en_q && (thresh_q != 8'd0) && (count8 >= thresh_q);
      irq_en_d = wr_ctrl ? out_port[0] : irq_en_q;
      thresh_d = wr_thresh ? out_port : thresh_q;
      irq_d    = irq_q;
      armed_d  = !irq_cond;
      if (irq_cond && armed_q) irq_d = 1'b1;
      if (interrupt_ack || (wr_ctrl && !out_port[0])) irq_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         thresh_q <= RESET_THRESH;
         armed_q  <= 1'b1;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         thresh_q <= thresh_d;
         armed_q  <= armed_d;
         irq_q    <= irq_d;
      end
   end
`else
   logic unused_irq;
   assign unused_irq = interrupt_ack ^ wr_thresh;
   assign irq_en_q   = 1'b0;
   assign thresh_q   = 8'd0;
   assign irq_q      = 1'b0;
`endif

   assign status = {overflow_q, underflow_q, overrun_q, play_valid_q, irq_q, full, empty, 1'b0};

   always_comb begin
      rdata = 8'd0;
      if (in_window) begin
         case (offset[2:0])
            3'd0:    rdata = empty ? 8'd0 : mem[rd_ptr_q];
            3'd1:    rdata = status;
            3'd2:    rdata = count8;
            3'd3:    rdata = play_data_q;
            3'd4:    rdata = {7'd0, irq_en_q};
            3'd5:    rdata = thresh_q;
            default: rdata = 8'd0;
         endcase
      end
   end

   // Storage needs no reset: empty reads are forced to zero by the pointer state
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_q] <= rec_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         overrun_q    <= 1'b0;
         play_valid_q <= 1'b0;
         play_data_q  <= 8'd0;
         in_port      <= 8'd0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         overrun_q    <= overrun_d;
         play_valid_q <= play_valid_d;
         play_data_q  <= play_data_d;
         in_port      <= rdata;
      end
   end

   assign interrupt  = irq_q;
   assign play_valid = play_valid_q;
   assign play_data  = play_data_q;

endmodule

// File: tb/tb_pb_audio_port.sv
// Self-checking bench for pb_audio_port: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_pb_audio_port;
   localparam logic [7:0] BASE = 8'h00;
   localparam int DEPTH = 16;
`ifdef PB_AUDIO_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] port_id = 8'd0;
   logic       read_strobe = 1'b0;
   logic       write_strobe = 1'b0;
   logic [7:0] out_port = 8'd0;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;
   logic       rec_valid = 1'b0;
   logic [7:0] rec_data = 8'd0;
   logic       play_valid;
   logic [7:0] play_data;
   logic       play_ready = 1'b0;

   int vectors = 0;
   int errors = 0;

   pb_audio_port #(
      .BASE_ADDR    (BASE),
      .DEPTH_LOG2   (4),
      .RESET_THRESH (8'd8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .port_id       (port_id),
      .read_strobe   (read_strobe),
      .write_strobe  (write_strobe),
      .out_port      (out_port),
      .in_port       (in_port),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .rec_valid     (rec_valid),
      .rec_data      (rec_data),
      .play_valid    (play_valid),
      .play_data     (play_data),
      .play_ready    (play_ready)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] q[$];
   bit         m_ovf, m_udf, m_povr, m_pv, m_irq, m_irq_en, m_armed;
   logic [7:0] m_pd, m_thr, m_in;

   task automatic model_reset();
      q.delete();
      {m_ovf, m_udf, m_povr, m_pv, m_irq, m_irq_en} = '0;
      m_armed = 1'b1;
      m_pd    = 8'd0;
      m_thr   = IRQ ? 8'd8 : 8'd0;
      m_in    = 8'd0;
   endtask

   // Applies the rules for one rising edge using the inputs currently driven
   task automatic model_edge();
      logic [8:0] diff;
      logic [7:0] off;
      bit win, wr, rd, cond, pop, push, fl, clr;
      int n;
      diff = {1'b0, port_id} - {1'b0, BASE};
      off  = diff[7:0];
      win  = diff < 9'd6;
      wr   = write_strobe && win;
      rd   = read_strobe && win;
      n    = q.size();
      m_in = 8'd0;
      if (win) begin
         case (off)
            8'd0: m_in = (n > 0) ? q[0] : 8'd0;
            8'd1: m_in = {m_ovf, m_udf, m_povr, m_pv, m_irq, n == DEPTH, n == 0, 1'b0};
            8'd2: m_in = 8'(n);
            8'd3: m_in = m_pd;
            8'd4: m_in = {7'd0, m_irq_en};
            8'd5: m_in = m_thr;
            default: m_in = 8'd0;
         endcase
      end
      cond = IRQ && m_irq_en && (m_thr != 0) && (n >= int'(m_thr));
      if (cond && m_armed) m_irq = 1'b1;
      m_armed = !cond;
      if (interrupt_ack || (wr && off == 8'd4 && !out_port[0])) m_irq = 1'b0;
      pop  = rd && off == 8'd0;
      push = rec_valid;
      fl   = wr && off == 8'd4 && out_port[2];
      clr  = wr && off == 8'd4 && out_port[1];
      if (push && n == DEPTH) m_ovf = 1'b1;
      if (pop && n == 0) m_udf = 1'b1;
      if (fl) q.delete();
      else begin
         if (pop && n > 0) void'(q.pop_front());
         if (push && n < DEPTH) q.push_back(rec_data);
      end
      if (wr && off == 8'd3) begin
         if (m_pv && !play_ready) m_povr = 1'b1;
         m_pv = 1'b1;
         m_pd = out_port;
      end else if (m_pv && play_ready) m_pv = 1'b0;
      if (wr && off == 8'd4) m_irq_en = IRQ && out_port[0];
      if (wr && off == 8'd5 && IRQ) m_thr = out_port;
      if (clr) {m_ovf, m_udf, m_povr} = '0;
   endtask

   task automatic tick();
      if (reset) model_reset();
      else model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_peek(input logic [7:0] off, output logic [7:0] val);
      port_id = BASE + off;
      tick();
      val = in_port;
   endtask

   task automatic cpu_pop(output logic [7:0] val);
      port_id = BASE;
      tick();
      val = in_port;
      read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] off, input logic [7:0] data);
      port_id      = BASE + off;
      out_port     = data;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
   endtask

   task automatic push(input logic [7:0] data);
      rec_valid = 1'b1;
      rec_data  = data;
      tick();
      rec_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      logic [7:0] exp_regs [6];
      exp_regs = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, IRQ ? 8'h08 : 8'h00};
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      vectors++;
      if (interrupt !== 1'b0 || play_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: irq=%b play_valid=%b, want 0 0", interrupt, play_valid);
      end
      for (int i = 0; i < 6; i++) begin
         cpu_peek(8'(i), v);
         vectors++;
         if (v !== exp_regs[i]) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h want %h", i, v, exp_regs[i]);
         end
      end
   endtask

   task automatic test_fifo_order();
      logic [7:0] v;
      logic [7:0] samples [3];
      samples = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) push(samples[i]);
      cpu_peek(8'd2, v);
      vectors++;
      if (v !== 8'd3) begin errors++; $display("FAIL fifo_count3: got %h want 03", v); end
      for (int i = 0; i < 3; i++) begin
         cpu_pop(v);
         vectors++;
         if (v !== samples[i]) begin
            errors++;
            $display("FAIL fifo_pop%0d: got %h want %h", i, v, samples[i]);
         end
      end
      cpu_peek(8'd2, v);
      vectors++;
      if (v !== 8'd0) begin errors++; $display("FAIL fifo_count0: got %h want 00", v); end
      cpu_pop(v);
      vectors++;
      if (v !== 8'd0) begin errors++; $display("FAIL fifo_empty_pop: got %h want 00", v); end
      cpu_peek(8'd1, v);
      vectors++;
      if (v !== 8'h42) begin errors++; $display("FAIL underflow_status: got %h want 42", v); end
      cpu_write(8'd4, 8'h02);
      cpu_peek(8'd1, v);
      vectors++;
      if (v !== 8'h02) begin errors++; $display("FAIL clear_status: got %h want 02", v); end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      for (int i = 0; i < 17; i++) push(8'(i + 8'h40));
      cpu_peek(8'd2, v);
      vectors++;
      if (v !== 8'd16) begin errors++; $display("FAIL ovf_count: got %h want 10", v); end
      cpu_peek(8'd1, v);
      vectors++;
      if (v !== 8'h84) begin errors++; $display("FAIL ovf_status: got %h want 84", v); end
      cpu_write(8'd4, 8'h02);
      cpu_peek(8'd1, v);
      vectors++;
      if (v !== 8'h04) begin errors++; $display("FAIL ovf_clear: got %h want 04", v); end
      cpu_pop(v);
      vectors++;
      if (v !== 8'h40) begin errors++; $display("FAIL ovf_head: got %h want 40", v); end
      cpu_write(8'd4, 8'h04);
      cpu_peek(8'd2, v);
      vectors++;
      if (v !== 8'd0) begin errors++; $display("FAIL flush_count: got %h want 00", v); end
   endtask

`ifdef PB_AUDIO_IRQ_EN
   task automatic test_irq();
      logic [7:0] v;
      cpu_write(8'd5, 8'd4);
      cpu_write(8'd4, 8'h01);
      for (int i = 0; i < 3; i++) push(8'(i));
      tick();
      vectors++;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_below: got %b want 0", interrupt); end
      push(8'h03);
      tick();
      vectors++;
      if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", interrupt); end
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
      vectors++;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_ack: got %b want 0", interrupt); end
      push(8'h04);
      tick();
      tick();
      vectors++;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_no_refire: got %b want 0", interrupt); end
      cpu_pop(v);
      cpu_pop(v);
      push(8'h05);
      tick();
      vectors++;
      if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_rearm: got %b want 1", interrupt); end
      cpu_write(8'd4, 8'h04);
      vectors++;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b want 0", interrupt); end
      cpu_write(8'd5, 8'd8);
   endtask
`else
   task automatic test_irq();
      logic [7:0] v;
      cpu_write(8'd5, 8'd4);
      cpu_write(8'd4, 8'h01);
      for (int i = 0; i < 5; i++) push(8'(i));
      tick();
      vectors++;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b want 0", interrupt); end
      cpu_peek(8'd4, v);
      vectors++;
      if (v !== 8'h00) begin errors++; $display("FAIL ctrl_read: got %h want 00", v); end
      cpu_peek(8'd5, v);
      vectors++;
      if (v !== 8'h00) begin errors++; $display("FAIL thresh_read: got %h want 00", v); end
      cpu_write(8'd4, 8'h04);
   endtask
`endif

   task automatic test_playback();
      logic [7:0] v;
      play_ready = 1'b0;
      cpu_write(8'd3, 8'hA5);
      vectors++;
      if (play_valid !== 1'b1 || play_data !== 8'hA5) begin
         errors++;
         $display("FAIL play_load: got %b/%h want 1/a5", play_valid, play_data);
      end
      cpu_write(8'd3, 8'h5A);
      vectors++;
      if (play_valid !== 1'b1 || play_data !== 8'h5A) begin
         errors++;
         $display("FAIL play_overwrite: got %b/%h want 1/5a", play_valid, play_data);
      end
      cpu_peek(8'd1, v);
      vectors++;
      if (v !== 8'h32) begin errors++; $display("FAIL play_status: got %h want 32", v); end
      play_ready = 1'b1;
      tick();
      play_ready = 1'b0;
      vectors++;
      if (play_valid !== 1'b0) begin errors++; $display("FAIL play_accept: got %b want 0", play_valid); end
      cpu_peek(8'd3, v);
      vectors++;
      if (v !== 8'h5A) begin errors++; $display("FAIL play_readback: got %h want 5a", v); end
      cpu_write(8'd4, 8'h02);
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      push(8'hAA);
      push(8'hBB);
      port_id = BASE;
      tick();
      v = in_port;
      read_strobe = 1'b1;
      rec_valid   = 1'b1;
      rec_data    = 8'hCC;
      tick();
      read_strobe = 1'b0;
      rec_valid   = 1'b0;
      vectors++;
      if (v !== 8'hAA) begin errors++; $display("FAIL b2b_head: got %h want aa", v); end
      cpu_peek(8'd2, v);
      vectors++;
      if (v !== 8'd2) begin errors++; $display("FAIL b2b_count: got %h want 02", v); end
      cpu_pop(v);
      vectors++;
      if (v !== 8'hBB) begin errors++; $display("FAIL b2b_pop1: got %h want bb", v); end
      cpu_pop(v);
      vectors++;
      if (v !== 8'hCC) begin errors++; $display("FAIL b2b_pop2: got %h want cc", v); end
   endtask

   task automatic test_random();
      int off;
      for (int i = 0; i < 600; i++) begin
         off          = int'($urandom_range(0, 7));
         port_id      = BASE + 8'(off);
         read_strobe  = ($urandom_range(0, 3) == 0);
         write_strobe = ($urandom_range(0, 5) == 0) && !read_strobe;
         out_port     = (off == 5) ? 8'($urandom_range(0, 12)) : 8'($urandom);
         rec_valid    = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
         rec_data     = 8'($urandom);
         play_ready   = 1'($urandom_range(0, 1));
         interrupt_ack = ($urandom_range(0, 7) == 0);
         tick();
         vectors++;
         if (in_port !== m_in || interrupt !== m_irq || play_valid !== m_pv ||
             play_data !== m_pd) begin
            errors++;
            $display("FAIL rand_cycle%0d: got in=%h irq=%b pv=%b pd=%h want in=%h irq=%b pv=%b pd=%h",
                     i, in_port, interrupt, play_valid, play_data, m_in, m_irq, m_pv, m_pd);
         end
      end
      read_strobe   = 1'b0;
      write_strobe  = 1'b0;
      rec_valid     = 1'b0;
      play_ready    = 1'b0;
      interrupt_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      for (int i = 0; i < 3; i++) push(8'(8'h90 + i));
      cpu_write(8'd3, 8'h77);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (play_valid !== 1'b0 || play_data !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_play: got %b/%h want 0/00", play_valid, play_data);
      end
      cpu_peek(8'd2, v);
      vectors++;
      if (v !== 8'd0) begin errors++; $display("FAIL mid_reset_count: got %h want 00", v); end
      cpu_peek(8'd0, v);
      vectors++;
      if (v !== 8'd0) begin errors++; $display("FAIL mid_reset_head: got %h want 00", v); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fifo_order();
      test_overflow();
      test_irq();
      test_playback();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
